pat_gen_sequencer: RTL and testbench
====================================

Name: pat_gen_sequencer

Overview:
- Runtime controller for the pattern generator: reads pattern bytes from pattern memory in order from address 0 to end_address and emits them as timed samples on gpio_out.
- Takes its run controls from the register-map outputs (enable, repeat, end address, GPIO width, timestep).
- Shares the pattern memory read port with host access through a req/gnt handshake.
- Prefetches one byte ahead so the output stays continuous.

Parameters:
- AW, 24, pattern memory address width; matches the end_address register field.
- TS_W, 5, width of the timestep select.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- enable  input  1  run enable, level; rising edge starts a run, low aborts
- repeat_enable  input  1  wrap to address 0 after end_address instead of stopping
- end_address  input  AW  last pattern byte address, inclusive
- num_gpio_sel  input  2  bits per sample: 0=1, 1=2, 2=4, 3=8
- timestep_sel  input  TS_W  sample hold time = timestep_sel+1 clk cycles
- mem_req  output  1  read request, held until granted
- mem_addr  output  AW  read address, stable while mem_req=1
- mem_gnt  input  1  grant; the read is accepted in a cycle where mem_req&mem_gnt
- mem_rdata  input  8  read data, valid exactly 1 cycle after the accepting cycle
- gpio_out  output  8  pattern sample; unused upper bits driven 0
- busy  output  1  run in progress (PRIME or RUN)
- done  output  1  non-repeat run completed; held until enable low
- underrun  output  1  sticky; a sample boundary arrived with no byte available

Behaviour:
- Reset clears everything: gpio_out=0, busy=0, done=0, underrun=0, mem_req=0, mem_addr=0, state IDLE, buffer empty.
- States: IDLE, PRIME, RUN, DONE.
- IDLE:
  - A rising edge of enable (registered edge detect) latches end_address, repeat_enable, num_gpio_sel and timestep_sel into shadow registers.
  - Clears underrun, sets fetch address to 0, goes to PRIME.
  - Input changes after latching are ignored until the next start.
- Fetch engine:
  - At most one read outstanding.
  - Issues a read whenever the prefetch buffer is empty or being consumed, and no read is outstanding.
  - On accept: fetch address = 0 if it equals end_address and repeat is set; otherwise fetch address + 1.
  - In non-repeat mode, no reads are issued past end_address.
- PRIME:
  - The first returned byte loads the shift register.
  - Enters RUN the cycle after that load; gpio_out shows sample 0 in that first RUN cycle.
  - Prefetch of the next byte starts immediately.
- RUN, sample extraction:
  - Samples are taken LSB-first: gpio_out = shift[W-1:0], with W from num_gpio_sel.
  - Samples per byte = 8/W.
- RUN, timing:
  - A hold counter counts 0..timestep_sel.
  - At terminal count, the next sample is presented on the following clk: shift right by W, or load from the prefetch buffer after the last sample of the byte.
- Underrun:
  - If the buffer is empty when a byte load is due, gpio_out holds its current value, underrun=1 (sticky), and the hold counter freezes.
  - Output resumes on the cycle after the byte arrives.
  - At 1 sample/cycle with 8-bit samples, underrun is expected; this is accepted behaviour.
- End of pattern:
  - After the last sample of byte end_address: repeat=1 continues with byte 0 with no gap, provided it is buffered.
  - repeat=0 goes to DONE: gpio_out=0, done=1, mem_req=0.
- DONE: stays until enable=0, then IDLE with done=0.
- Abort: enable=0 in PRIME or RUN returns to IDLE next cycle with gpio_out=0 and busy=0. Any outstanding read's data is discarded. mem_req may drop without gnt.
- Reset mid-run: immediate IDLE with all outputs at reset values.
- end_address=0 is a single-byte pattern.
- Address wrap is only to 0; there is no arithmetic overflow because the fetch address never exceeds end_address.
- busy=1 in PRIME and RUN only.

Test Plan:
- Basic run: mem[0..1]=A5,3C; end=1, sel=0 (1 bit), ts=0, repeat=0, mem_gnt tied 1.
  - gpio_out[0] sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0, one clk each.
  - Then done=1, gpio_out=0.
- Width and timestep: mem[0]=E4, end=0, sel=1 (2 bit), ts=2.
  - gpio_out[1:0] = 0,1,2,3, each held exactly 3 clks.
  - Then done.
- Repeat wrap: mem[0..2]=11,22,33, end=2, sel=3, ts=3, repeat=1.
  - Output 11,22,33,11,22,... each 4 clks, with no gap at the wrap.
  - busy stays 1 and underrun stays 0.
- Underrun: sel=3, ts=0, mem_gnt asserted every 4th cycle.
  - underrun goes to 1; gpio_out holds its value during stalls.
  - Every byte still appears, in order.
- Abort and restart: drop enable mid-RUN.
  - Next cycle: gpio_out=0, busy=0, IDLE.
  - Re-raise enable with new end=0: the run restarts from address 0 with the new config.
- Reset during PRIME with a read outstanding: all outputs return to 0 immediately; the late mem_rdata is ignored.

Source files
------------

// File: rtl/pat_gen_sequencer.sv
// pat_gen_sequencer
//   Runtime controller for the pattern generator. It walks pattern memory
//   from address 0 to end_address and emits each byte as a series of
//   timed samples on gpio_out. The memory read port is shared with host
//   access through a req/gnt handshake. One byte is prefetched ahead so the
//   output stays continuous.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   enable          run level; rising edge starts, low aborts
//   repeat_enable   wrap to byte 0 after end_address
//   end_address     last pattern byte address (inclusive)
//   num_gpio_sel    bits per sample: 0=1, 1=2, 2=4, 3=8
//   timestep_sel    sample hold time = timestep_sel+1 cycles
//   mem_req/addr    read request (held until granted) and its address
//   mem_gnt         grant; read accepted when mem_req & mem_gnt
//   mem_rdata       read data, valid one cycle after acceptance
//   gpio_out        current sample, unused upper bits 0
//   busy            PRIME or RUN
//   done            non-repeat run finished, held until enable low
//   underrun        sticky: a byte load was due with no byte available
module pat_gen_sequencer #(
    parameter int AW   = 24,
    parameter int TS_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            repeat_enable,
    input  logic [AW-1:0]   end_address,
    input  logic [1:0]      num_gpio_sel,
    input  logic [TS_W-1:0] timestep_sel,
    output logic            mem_req,
    output logic [AW-1:0]   mem_addr,
    input  logic            mem_gnt,
    input  logic [7:0]      mem_rdata,
    output logic [7:0]      gpio_out,
    output logic            busy,
    output logic            done,
    output logic            underrun
);

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DONE} state_t;

    state_t          state_q;
    logic            en_q;
    logic [AW-1:0]   end_q;
    logic            rep_q;
    logic [1:0]      sel_q;
    logic [TS_W-1:0] ts_q;
    logic [AW-1:0]   addr_q;
    logic            fetch_done_q;  // non-repeat: end_address already fetched
    logic            pend_q;        // read accepted last cycle, data on mem_rdata now
    logic            pend_last_q;
    logic [7:0]      buf_q;
    logic            buf_valid_q;
    logic            buf_last_q;
    logic [7:0]      shift_q;
    logic            shift_last_q;  // byte in shift_q is the final one of the run
    logic [2:0]      left_q;        // samples remaining in shift_q after the current one
    logic [TS_W-1:0] hold_q;
    logic [7:0]      gpio_q;
    logic            underrun_q;

    logic [7:0] mask_d;
    logic [3:0] width_d;
    logic [2:0] last_idx_d;

    always_comb begin
        mask_d     = 8'h01;
        width_d    = 4'd1;
        last_idx_d = 3'd7;
        case (sel_q)
            2'd1: begin mask_d = 8'h03; width_d = 4'd2; last_idx_d = 3'd3; end
            2'd2: begin mask_d = 8'h0F; width_d = 4'd4; last_idx_d = 3'd1; end
            2'd3: begin mask_d = 8'hFF; width_d = 4'd8; last_idx_d = 3'd0; end
            default: ;
        endcase
    end

    logic       hold_tc_d;
    logic       byte_due_d;
    logic       consume_d;
    logic       avail_d;
    logic       accept_d;
    logic [7:0] shift_next_d;
    logic [7:0] load_byte_d;
    logic       load_last_d;

    assign hold_tc_d    = (hold_q == ts_q);
    assign byte_due_d   = (state_q == S_RUN) && hold_tc_d && (left_q == 3'd0) && !shift_last_q;
    assign consume_d    = byte_due_d && buf_valid_q;
    // A byte is available either from the buffer or straight off mem_rdata.
    assign avail_d      = buf_valid_q || pend_q;
    assign load_byte_d  = buf_valid_q ? buf_q : mem_rdata;
    assign load_last_d  = buf_valid_q ? buf_last_q : pend_last_q;
    assign shift_next_d = shift_q >> width_d;

    // Request stays up across un-granted cycles: once the buffer is empty it
    // can only refill through this very request, so the condition holds.
    assign mem_req  = ((state_q == S_PRIME) || (state_q == S_RUN)) && !pend_q &&
                      !fetch_done_q && (!buf_valid_q || consume_d);
    assign accept_d = mem_req && mem_gnt;

    assign mem_addr = addr_q;
    assign gpio_out = gpio_q;
    assign busy     = (state_q == S_PRIME) || (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign underrun = underrun_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            en_q         <= 1'b0;
            end_q        <= '0;
            rep_q        <= 1'b0;
            sel_q        <= 2'd0;
            ts_q         <= '0;
            addr_q       <= '0;
            fetch_done_q <= 1'b0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            buf_q        <= 8'h00;
            buf_valid_q  <= 1'b0;
            buf_last_q   <= 1'b0;
            shift_q      <= 8'h00;
            shift_last_q <= 1'b0;
            left_q       <= 3'd0;
            hold_q       <= '0;
            gpio_q       <= 8'h00;
            underrun_q   <= 1'b0;
        end else begin
            en_q   <= enable;
            pend_q <= accept_d;

            if (accept_d) begin
                pend_last_q <= (addr_q == end_q) && !rep_q;
                if (addr_q == end_q) begin
                    if (rep_q) addr_q <= '0;
                    else       fetch_done_q <= 1'b1;
                end else begin
                    addr_q <= addr_q + AW'(1);
                end
            end

            case (state_q)
                S_IDLE: begin
                    gpio_q <= 8'h00;
                    if (enable && !en_q) begin
                        end_q        <= end_address;
                        rep_q        <= repeat_enable;
                        sel_q        <= num_gpio_sel;
                        ts_q         <= timestep_sel;
                        underrun_q   <= 1'b0;
                        addr_q       <= '0;
                        fetch_done_q <= 1'b0;
                        buf_valid_q  <= 1'b0;
                        state_q      <= S_PRIME;
                    end
                end
                S_PRIME: begin
                    if (!enable) begin
                        state_q     <= S_IDLE;
                        gpio_q      <= 8'h00;
                        pend_q      <= 1'b0;
                        buf_valid_q <= 1'b0;
                    end else if (pend_q) begin
                        shift_q      <= mem_rdata;
                        shift_last_q <= pend_last_q;
                        gpio_q       <= mem_rdata & mask_d;
                        left_q       <= last_idx_d;
                        hold_q       <= '0;
                        state_q      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!enable) begin
                        state_q     <= S_IDLE;
                        gpio_q      <= 8'h00;
                        pend_q      <= 1'b0;
                        buf_valid_q <= 1'b0;
                    end else begin
                        // Returning data parks in the buffer unless it is
                        // consumed directly this cycle to end an underrun.
                        if (pend_q && !(byte_due_d && !buf_valid_q)) begin
                            buf_q       <= mem_rdata;
                            buf_valid_q <= 1'b1;
                            buf_last_q  <= pend_last_q;
                        end
                        if (hold_tc_d) begin
                            if (left_q != 3'd0) begin
                                shift_q <= shift_next_d;
                                gpio_q  <= shift_next_d & mask_d;
                                left_q  <= left_q - 3'd1;
                                hold_q  <= '0;
                            end else if (shift_last_q) begin
                                state_q <= S_DONE;
                                gpio_q  <= 8'h00;
                            end else if (avail_d) begin
                                shift_q      <= load_byte_d;
                                shift_last_q <= load_last_d;
                                gpio_q       <= load_byte_d & mask_d;
                                left_q       <= last_idx_d;
                                hold_q       <= '0;
                                if (buf_valid_q) buf_valid_q <= 1'b0;
                            end else begin
                                // Stall: output and hold counter stay put.
                                underrun_q <= 1'b1;
                            end
                        end else begin
                            hold_q <= hold_q + TS_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    gpio_q <= 8'h00;
                    if (!enable) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pat_gen_sequencer.sv
module tb_pat_gen_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        repeat_enable;
    logic [23:0] end_address;
    logic [1:0]  num_gpio_sel;
    logic [4:0]  timestep_sel;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_gnt;
    logic [7:0]  mem_rdata;
    logic [7:0]  gpio_out;
    logic        busy;
    logic        done;
    logic        underrun;

    always #5 clk = ~clk;

    pat_gen_sequencer #(.AW(24), .TS_W(5)) dut (
        .clk(clk), .rst(rst), .enable(enable), .repeat_enable(repeat_enable),
        .end_address(end_address), .num_gpio_sel(num_gpio_sel),
        .timestep_sel(timestep_sel), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .gpio_out(gpio_out),
        .busy(busy), .done(done), .underrun(underrun)
    );

    typedef struct {
        int         tag;
        logic [7:0] gpio;
        logic       busy;
        logic       done;
        logic       unr;
    } exp_t;

    exp_t       cyc_q[$];
    logic [7:0] byte_q[$];
    int n_vec = 0;
    int n_bad = 0;
    int mode = 0;       // 0: per-cycle checks, 1: check each new sample value
    int gnt_mode = 0;   // 0: grant always, 1: grant every 4th cycle
    int cyc = 0;

    logic [7:0] mem [16];
    logic       acc_s = 1'b0;
    logic [3:0] acc_addr = 4'd0;

    // Memory: a read accepted in a cycle returns data throughout the next.
    always @(negedge clk) begin
        acc_s    = mem_req && mem_gnt;
        acc_addr = mem_addr[3:0];
    end

    initial begin
        mem_rdata = 8'hEE;
        mem_gnt   = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            mem_rdata = acc_s ? mem[acc_addr] : 8'hEE;
            mem_gnt   = (gnt_mode == 0) ? 1'b1 : ((cyc % 4) == 0);
        end
    end

    // Monitor / scoreboard.
    initial begin
        exp_t       e;
        logic [7:0] prev;
        logic [7:0] eb;
        prev = 8'h00;
        forever begin
            @(negedge clk);
            if (mode == 0) begin
                if (cyc_q.size() > 0) begin
                    e = cyc_q.pop_front();
                    n_vec++;
                    if (gpio_out !== e.gpio || busy !== e.busy || done !== e.done || underrun !== e.unr) begin
                        n_bad++;
                        $display("FAIL cyc_chk[t%0d]: got gpio=%02h busy=%b done=%b unr=%b, expected gpio=%02h busy=%b done=%b unr=%b",
                                 e.tag, gpio_out, busy, done, underrun, e.gpio, e.busy, e.done, e.unr);
                    end
                end
            end else if (busy && gpio_out !== prev) begin
                n_vec++;
                if (byte_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sample_seq: got unexpected sample %02h, expected none", gpio_out);
                end else begin
                    eb = byte_q.pop_front();
                    if (gpio_out !== eb) begin
                        n_bad++;
                        $display("FAIL sample_seq: got %02h expected %02h", gpio_out, eb);
                    end
                end
            end
            prev = gpio_out;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int tag, input logic [7:0] g, input logic b, input logic d,
                        input logic u, input int n);
        exp_t e;
        e.tag = tag; e.gpio = g; e.busy = b; e.done = d; e.unr = u;
        for (int i = 0; i < n; i++) cyc_q.push_back(e);
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int k;
        k = 0;
        while ((cyc_q.size() != 0 || byte_q.size() != 0) && k < budget) begin
            @(posedge clk);
            k++;
        end
        n_vec++;
        if (k >= budget) begin
            n_bad++;
            $display("FAIL %s: got %0d items pending after %0d cycles, expected 0",
                     nm, cyc_q.size() + byte_q.size(), budget);
            cyc_q.delete();
            byte_q.delete();
        end
    endtask

    // Called right after a posedge+1: applies config and raises enable (cycle 0).
    task automatic start_run(input logic [23:0] ea, input logic [1:0] sel,
                             input logic [4:0] ts, input logic rep);
        end_address   = ea;
        num_gpio_sel  = sel;
        timestep_sel  = ts;
        repeat_enable = rep;
        enable        = 1'b1;
    endtask

    task automatic stop_run(input string nm);
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk({nm, "_done_clr"}, done, 1'b0);
        chk({nm, "_busy_clr"}, busy, 1'b0);
    endtask

    logic       tv1 [16] = '{1,0,1,0, 0,1,0,1, 0,0,1,1, 1,1,0,0};
    logic [7:0] tv3 [8]  = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33, 8'h11, 8'h22};

    initial begin
        int k;
        rst = 1'b1; enable = 1'b0; repeat_enable = 1'b0; end_address = '0;
        num_gpio_sel = 2'd0; timestep_sel = '0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gpio", gpio_out, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_unr", underrun, 1'b0);
        chk("rst_req", mem_req, 1'b0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Basic run: A5,3C at 1 bit per sample, 1 clk each.
        mem[0] = 8'hA5; mem[1] = 8'h3C;
        @(posedge clk); #1;
        start_run(24'd1, 2'd0, 5'd0, 1'b0);
        push(1, 8'h00, 1'b0, 1'b0, 1'b0, 1);
        push(1, 8'h00, 1'b1, 1'b0, 1'b0, 2);
        for (int i = 0; i < 16; i++) push(1, {7'd0, tv1[i]}, 1'b1, 1'b0, 1'b0, 1);
        push(1, 8'h00, 1'b0, 1'b1, 1'b0, 3);
        wait_drain("t1_drain", 100);
        stop_run("t1");

        // Width and timestep: E4 at 2 bits, each sample held 3 clks.
        mem[0] = 8'hE4;
        @(posedge clk); #1;
        start_run(24'd0, 2'd1, 5'd2, 1'b0);
        push(2, 8'h00, 1'b0, 1'b0, 1'b0, 1);
        push(2, 8'h00, 1'b1, 1'b0, 1'b0, 2);
        push(2, 8'h00, 1'b1, 1'b0, 1'b0, 3);
        push(2, 8'h01, 1'b1, 1'b0, 1'b0, 3);
        push(2, 8'h02, 1'b1, 1'b0, 1'b0, 3);
        push(2, 8'h03, 1'b1, 1'b0, 1'b0, 3);
        push(2, 8'h00, 1'b0, 1'b1, 1'b0, 2);
        wait_drain("t2_drain", 100);
        stop_run("t2");

        // Repeat wrap 11,22,33 at 8 bits, 4 clks each, then abort mid-RUN.
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
        @(posedge clk); #1;
        start_run(24'd2, 2'd3, 5'd3, 1'b1);
        push(3, 8'h00, 1'b0, 1'b0, 1'b0, 1);
        push(3, 8'h00, 1'b1, 1'b0, 1'b0, 2);
        for (int i = 0; i < 7; i++) push(3, tv3[i], 1'b1, 1'b0, 1'b0, 4);
        push(3, tv3[7], 1'b1, 1'b0, 1'b0, 1);
        push(5, 8'h00, 1'b0, 1'b0, 1'b0, 2);
        repeat (31) @(posedge clk);
        #1;
        enable = 1'b0;
        wait_drain("t3_drain", 100);

        // Restart with new config end=0, 4 bits, hold 2: byte 0 = 11.
        @(posedge clk); #1;
        start_run(24'd0, 2'd2, 5'd1, 1'b0);
        push(5, 8'h00, 1'b0, 1'b0, 1'b0, 1);
        push(5, 8'h00, 1'b1, 1'b0, 1'b0, 2);
        push(5, 8'h01, 1'b1, 1'b0, 1'b0, 4);
        push(5, 8'h00, 1'b0, 1'b1, 1'b0, 2);
        wait_drain("t5_drain", 100);
        stop_run("t5");

        // Underrun: 8-bit samples at 1 clk, grant only every 4th cycle.
        mem[0] = 8'h10; mem[1] = 8'h21; mem[2] = 8'h32; mem[3] = 8'h43; mem[4] = 8'h54;
        gnt_mode = 1;
        mode = 1;
        for (int i = 0; i < 5; i++) byte_q.push_back(mem[i]);
        @(posedge clk); #1;
        start_run(24'd4, 2'd3, 5'd0, 1'b0);
        k = 0;
        while (done !== 1'b1 && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        chk("t4_done", done, 1'b1);
        chk("t4_underrun", underrun, 1'b1);
        chk("t4_gpio_done", gpio_out, 8'h00);
        wait_drain("t4_drain", 10);
        mode = 0;
        gnt_mode = 0;
        stop_run("t4");

        // Reset during PRIME with a read outstanding.
        chk("t6_unr_sticky", underrun, 1'b1);
        @(posedge clk); #1;
        start_run(24'd3, 2'd0, 5'd0, 1'b0);
        @(posedge clk); #1;
        chk("t6_prime_busy", busy, 1'b1);
        chk("t6_unr_cleared", underrun, 1'b0);
        @(posedge clk); #1;
        chk("t6_addr_adv", mem_addr, 24'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_gpio", gpio_out, 8'h00);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_req", mem_req, 1'b0);
        chk("t6_rst_addr", mem_addr, 24'd0);
        enable = 1'b0;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_post_busy", busy, 1'b0);
            chk("t6_post_gpio", gpio_out, 8'h00);
            chk("t6_post_done", done, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
